// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and port identifiers for the dmem arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_LDR = 1'b1;

    localparam int DMEM_ADDR_W = 14;
    localparam int DMEM_DATA_W = 32;

    // Request bundle at the default dmem geometry, for integration code.
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
        logic [DMEM_DATA_W/8-1:0] wbe;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
// dmem_arb_pick : combinational one-hot grant selection for two ports.
// Policy is round-robin unless ARB_CPU_PRIORITY_EN selects CPU priority.
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  port_id_t   last_grant_i,
    input  logic       starve_i,
    output logic [1:0] grant_o
);

`ifdef ARB_CPU_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_o = 2'b00;
        if (valid_i[1] && (starve_i || !valid_i[0])) begin
            grant_o = 2'b10;
        end else if (valid_i[0]) begin
            grant_o = 2'b01;
        end
    end
`else
    logic unused_starve;
    assign unused_starve = starve_i;

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = (last_grant_i == PORT_CPU) ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares one synchronous BRAM port between CPU and loader,
// routing one-cycle read responses back to their owner.
// Optional macro ARB_CPU_PRIORITY_EN : CPU priority with loader anti-starvation.
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_req_wbe,
    output logic                    p0_resp_valid,
    output logic [DATA_WIDTH-1:0]   p0_resp_rdata,

    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_req_wbe,
    output logic                    p1_resp_valid,
    output logic [DATA_WIDTH-1:0]   p1_resp_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam int BE_W = DATA_WIDTH / 8;

    logic [1:0]      w_valid;
    logic [1:0]      w_grant;
    logic            w_starve;
    logic            w_sel_ldr;
    logic [BE_W-1:0] w_sel_wbe;

    port_id_t last_grant_q, last_grant_d;
    logic     rd_pending_q, rd_pending_d;
    port_id_t rd_owner_q,   rd_owner_d;

    assign w_valid = {p1_req_valid, p0_req_valid};

    dmem_arb_pick u_pick (
        .valid_i      (w_valid),
        .last_grant_i (last_grant_q),
        .starve_i     (w_starve),
        .grant_o      (w_grant)
    );

`ifdef ARB_CPU_PRIORITY_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign w_starve = (starve_cnt_q == C_STARVE_MAX);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_grant[1]) begin
            starve_cnt_d = '0;
        end else if (p1_req_valid && !w_starve) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT != 0);
    assign w_starve          = 1'b0;
`endif

    // Granted port's fields go straight to the BRAM; mem_dout never reaches a ready.
    assign w_sel_ldr    = w_grant[1];
    assign w_sel_wbe    = w_sel_ldr ? p1_req_wbe : p0_req_wbe;
    assign mem_en       = |w_grant;
    assign mem_we       = mem_en ? w_sel_wbe : '0;
    assign mem_addr     = w_sel_ldr ? p1_req_addr  : p0_req_addr;
    assign mem_din      = w_sel_ldr ? p1_req_wdata : p0_req_wdata;
    assign p0_req_ready = w_grant[0];
    assign p1_req_ready = w_grant[1];

    always_comb begin
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_pending_d = mem_en && (w_sel_wbe == '0);
        if (mem_en) begin
            last_grant_d = w_sel_ldr ? PORT_LDR : PORT_CPU;
            rd_owner_d   = w_sel_ldr ? PORT_LDR : PORT_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_LDR;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= PORT_CPU;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign p0_resp_valid = rd_pending_q && (rd_owner_q == PORT_CPU);
    assign p1_resp_valid = rd_pending_q && (rd_owner_q == PORT_LDR);
    assign p0_resp_rdata = mem_dout;
    assign p1_resp_rdata = mem_dout;

endmodule

`default_nettype wire
